mul_div_seq: RTL

- Iterative sequencer for the RV M-extension multiply/divide operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, plus RV64 W-forms).
- Sits in the EX stage beside the main ALU and drives a radix-2 shift-add / restoring-divide datapath, one bit per cycle.
- Holds the pipeline through its busy output and returns one result with a single-cycle done pulse.

---
 rtl/mul_div_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mul_div_seq.sv
// Iterative RV M-extension multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with single-cycle fast paths for divide special cases.
module mul_div_seq #(
   parameter logic [1:0] XLEN = 2'd2,
   localparam int W = 1 << (int'(XLEN) + 4)
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [2:0]   i_md_op,
   input  logic         i_word,
   input  logic [W-1:0] i_op_a,
   input  logic [W-1:0] i_op_b,
   input  logic         i_flush,
   output logic         o_ready,
   output logic         o_busy,
   output logic         o_done,
   output logic [W-1:0] o_result
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam logic [W-1:0] LOW_MASK = W'(32'hFFFF_FFFF);
   localparam logic [W-1:0] MIN_32   = W'(32'h8000_0000);
   localparam logic [W-1:0] MIN_W    = {1'b1, {(W-1){1'b0}}};

   state_t           state, state_nxt;
   logic [2:0]       op_q;
   logic             word_q, neg_q;
   logic [2*W-1:0]   acc;
   logic [W-1:0]     mcand;
   logic [6:0]       cnt;
   logic [W-1:0]     res_q;

   function automatic logic [W-1:0] sext_w(input logic [W-1:0] x, input logic word);
      return word ? ((x & LOW_MASK) | ({W{x[31]}} & ~LOW_MASK)) : x;
   endfunction

   // Operand decode: W-forms work on the low 32 bits, signed operands become magnitudes
   logic           word_in, is_div_in, is_rem_in, a_signed_in, b_signed_in, sa, sb;
   logic [W-1:0]   eff_mask, a_ext, b_ext, a_mag, b_mag, dividend_init;
   logic           b_zero, overflow, special, accept;
   logic [W-1:0]   special_raw, special_res;

   assign word_in       = (W > 32) && i_word;
   assign is_div_in     = i_md_op[2];
   assign is_rem_in     = i_md_op[2] & i_md_op[1];
   assign a_signed_in   = is_div_in ? ~i_md_op[0] : (i_md_op == 3'd1 || i_md_op == 3'd2);
   assign b_signed_in   = is_div_in ? ~i_md_op[0] : (i_md_op == 3'd1);
   assign eff_mask      = word_in ? LOW_MASK : '1;
   assign a_ext         = i_op_a & eff_mask;
   assign b_ext         = i_op_b & eff_mask;
   assign sa            = a_signed_in & (word_in ? i_op_a[31] : i_op_a[W-1]);
   assign sb            = b_signed_in & (word_in ? i_op_b[31] : i_op_b[W-1]);
   assign a_mag         = sa ? ((~a_ext + W'(1)) & eff_mask) : a_ext;
   assign b_mag         = sb ? ((~b_ext + W'(1)) & eff_mask) : b_ext;
   assign dividend_init = word_in ? (a_mag << (W - 32)) : a_mag;

   assign b_zero      = (b_ext == '0);
   assign overflow    = ~i_md_op[0] & (a_ext == (word_in ? MIN_32 : MIN_W)) & (b_ext == eff_mask);
   assign special     = is_div_in & (b_zero | overflow);
   assign special_raw = b_zero ? (is_rem_in ? a_ext : '1) : (is_rem_in ? '0 : a_ext);
   assign special_res = sext_w(special_raw, word_in);
   assign accept      = (state == IDLE || state == DONE) && i_start && !i_flush;

   // One iteration: multiply adds into the upper half then shifts right; divide shifts the
   // remainder left and keeps the trial difference when it does not go negative
   logic [W:0]       mul_sum, rem_sh, div_diff;
   logic [2*W-1:0]   mul_step, div_step;

   assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : '0);
   assign mul_step = {mul_sum, acc[W-1:1]};
   assign rem_sh   = {acc[2*W-1:W], acc[W-1]};
   assign div_diff = rem_sh - {1'b0, mcand};
   assign div_step = {div_diff[W] ? rem_sh[W-1:0] : div_diff[W-1:0], acc[W-2:0], ~div_diff[W]};

   // Word-mode multiplies finish after 32 shifts, so the product sits 32 bits higher
   logic [2*W-1:0]   prod, prod_s;
   logic [W-1:0]     mul_sel, div_sel, div_s, fix_res;

   assign prod    = word_q ? (acc >> (W - 32)) : acc;
   assign prod_s  = neg_q ? -prod : prod;
   assign mul_sel = (op_q == 3'd0) ? prod_s[W-1:0] : (word_q ? prod_s[W+31:32] : prod_s[2*W-1:W]);
   assign div_sel = op_q[1] ? acc[2*W-1:W] : acc[W-1:0];
   assign div_s   = neg_q ? -div_sel : div_sel;
   assign fix_res = sext_w(op_q[2] ? div_s : mul_sel, word_q);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (i_flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE, DONE: state_nxt = accept ? (special ? DONE : CALC) : IDLE;
            CALC:       if (cnt == '0) state_nxt = FIX;
            FIX:        state_nxt = DONE;
            default:    state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      o_ready = (state == IDLE) || (state == DONE);
      o_busy  = (state == CALC) || (state == FIX);
      o_done  = (state == DONE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_q   <= '0;
         word_q <= 1'b0;
         neg_q  <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         cnt    <= '0;
      end else if (accept) begin
         op_q   <= i_md_op;
         word_q <= word_in;
         neg_q  <= is_rem_in ? sa : (sa ^ sb);
         mcand  <= is_div_in ? b_mag : a_mag;
         acc    <= {{W{1'b0}}, is_div_in ? dividend_init : b_mag};
         cnt    <= word_in ? 7'd31 : 7'(W - 1);
      end else if (state == CALC) begin
         acc <= op_q[2] ? div_step : mul_step;
         if (cnt != '0) cnt <= cnt - 7'd1;
      end
   end

   // Result only changes on a fast-path accept or the FIX edge; a flush leaves it alone
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         res_q <= '0;
      end else if (accept && special) begin
         res_q <= special_res;
      end else if (state == FIX && !i_flush) begin
         res_q <= fix_res;
      end
   end

   assign o_result = res_q;

endmodule
